// File: rtl/mem_arbiter.sv
// mem_arbiter: NUM_CHANNELS independent channel FSMs that claim and relay consumer reads/writes.
// Optional MEM_ARB_ROUND_ROBIN_EN rotates the consumer search start; otherwise consumer 0 has fixed priority.
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 32,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]              mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_read_address,
  input  logic [NUM_CHANNELS-1:0]              mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_read_data,
  output logic [NUM_CHANNELS-1:0]              mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_write_data,
  input  logic [NUM_CHANNELS-1:0]              mem_write_ready
);

  localparam int CIDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_READ_WAITING   = 3'd1,
    ST_WRITE_WAITING  = 3'd2,
    ST_READ_RELAYING  = 3'd3,
    ST_WRITE_RELAYING = 3'd4
  } state_t;

  state_t                 state      [NUM_CHANNELS];
  state_t                 state_next [NUM_CHANNELS];
  logic [CIDX_BITS-1:0]   owner      [NUM_CHANNELS];
  logic [CIDX_BITS-1:0]   owner_next [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  claim_go;
  logic [NUM_CHANNELS-1:0]  claim_read;
  logic [NUM_CONSUMERS-1:0] claimed;
  logic [NUM_CONSUMERS-1:0] taken;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [CIDX_BITS-1:0]   rr_ptr;
  logic [CIDX_BITS-1:0]   rr_ptr_next;
`endif

  always_comb begin : p_next
    logic                 found;
    int                   start;
    int                   idx;
    logic [CIDX_BITS-1:0] cidx;
    found = 1'b0;
    idx   = 0;
    cidx  = '0;
    claimed = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (state[ch] != ST_IDLE) claimed[owner[ch]] = 1'b1;
    end
    // Consumers taken by lower-index channels this cycle are invisible to higher ones.
    taken = claimed;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    start       = int'(rr_ptr);
    rr_ptr_next = rr_ptr;
`else
    start = 0;
`endif
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_next[ch] = state[ch];
      owner_next[ch] = owner[ch];
      claim_go[ch]   = 1'b0;
      claim_read[ch] = 1'b0;
      case (state[ch])
        ST_IDLE: begin
          found = 1'b0;
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            idx  = (start + k) % NUM_CONSUMERS;
            cidx = CIDX_BITS'(idx);
            if (!found && !taken[cidx] &&
                (consumer_read_valid[cidx] || consumer_write_valid[cidx])) begin
              found          = 1'b1;
              taken[cidx]    = 1'b1;
              owner_next[ch] = cidx;
              claim_go[ch]   = 1'b1;
              claim_read[ch] = consumer_read_valid[cidx];
              state_next[ch] = consumer_read_valid[cidx] ? ST_READ_WAITING : ST_WRITE_WAITING;
`ifdef MEM_ARB_ROUND_ROBIN_EN
              rr_ptr_next    = CIDX_BITS'((idx + 1) % NUM_CONSUMERS);
`endif
            end
          end
        end
        ST_READ_WAITING:   if (mem_read_ready[ch])              state_next[ch] = ST_READ_RELAYING;
        ST_WRITE_WAITING:  if (mem_write_ready[ch])             state_next[ch] = ST_WRITE_RELAYING;
        ST_READ_RELAYING:  if (!consumer_read_valid[owner[ch]])  state_next[ch] = ST_IDLE;
        ST_WRITE_RELAYING: if (!consumer_write_valid[owner[ch]]) state_next[ch] = ST_IDLE;
        default:                                                 state_next[ch] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state[ch] <= ST_IDLE;
        owner[ch] <= '0;
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr <= '0;
`endif
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr <= rr_ptr_next;
`endif
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state[ch] <= state_next[ch];
        owner[ch] <= owner_next[ch];
        if (claim_go[ch]) begin
          if (claim_read[ch]) begin
            mem_read_valid[ch] <= 1'b1;
            mem_read_address[ch*ADDR_BITS +: ADDR_BITS] <=
              consumer_read_address[int'(owner_next[ch])*ADDR_BITS +: ADDR_BITS];
          end else begin
            mem_write_valid[ch] <= 1'b1;
            mem_write_address[ch*ADDR_BITS +: ADDR_BITS] <=
              consumer_write_address[int'(owner_next[ch])*ADDR_BITS +: ADDR_BITS];
            mem_write_data[ch*DATA_BITS +: DATA_BITS] <=
              consumer_write_data[int'(owner_next[ch])*DATA_BITS +: DATA_BITS];
          end
        end
        case (state[ch])
          ST_READ_WAITING: if (mem_read_ready[ch]) begin
            mem_read_valid[ch]          <= 1'b0;
            consumer_read_ready[owner[ch]] <= 1'b1;
            consumer_read_data[int'(owner[ch])*DATA_BITS +: DATA_BITS] <=
              mem_read_data[ch*DATA_BITS +: DATA_BITS];
          end
          ST_WRITE_WAITING: if (mem_write_ready[ch]) begin
            mem_write_valid[ch]             <= 1'b0;
            consumer_write_ready[owner[ch]] <= 1'b1;
          end
          ST_READ_RELAYING:
            if (!consumer_read_valid[owner[ch]]) consumer_read_ready[owner[ch]] <= 1'b0;
          ST_WRITE_RELAYING:
            if (!consumer_write_valid[owner[ch]]) consumer_write_ready[owner[ch]] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level consumer/memory model.
`default_nettype none

module tb_mem_arbiter;
  localparam int AB = 8, DB = 32, NC = 8, NCH = 4, TIMEOUT = 400;
  localparam int M_ALWAYS = 0, M_RANDOM = 1, M_STALL_HI = 2, M_STALL_ALL = 3;

  logic clk = 1'b0;
  logic reset;
  logic [NC-1:0]     consumer_read_valid, consumer_read_ready, consumer_write_valid, consumer_write_ready;
  logic [NC*AB-1:0]  consumer_read_address, consumer_write_address;
  logic [NC*DB-1:0]  consumer_read_data, consumer_write_data;
  logic [NCH-1:0]    mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [NCH*AB-1:0] mem_read_address, mem_write_address;
  logic [NCH*DB-1:0] mem_read_data, mem_write_data;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
  );

  int compared = 0, mismatched = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: consumers hold requests until served, memory answers from a fixed table.
  logic [DB-1:0] mem_model [256];
  bit            pend_rd [NC], pend_wr [NC], prev_rr [NC], prev_wr [NC];
  logic [AB-1:0] rd_addr [NC], wr_addr [NC];
  logic [DB-1:0] wr_data [NC];
  int            age [NC], issue_cyc [NC], last_lat [NC];
  logic [AB+DB-1:0] landed [$];
  int            order [$];
  int            rd_hs = 0, rd_served = 0, mode = M_ALWAYS, cycle = 0;
  bit            prev_mrv [NCH], prev_mwv [NCH];
  logic [AB-1:0] prev_mra [NCH], prev_mwa [NCH];
  logic [DB-1:0] prev_mwd [NCH];

  task automatic apply_inputs();
    for (int c = 0; c < NC; c++) begin
      consumer_read_valid[c]                 = pend_rd[c];
      consumer_read_address[c*AB +: AB]      = rd_addr[c];
      consumer_write_valid[c]                = pend_wr[c];
      consumer_write_address[c*AB +: AB]     = wr_addr[c];
      consumer_write_data[c*DB +: DB]        = wr_data[c];
    end
  endtask

  task automatic issue_rd(input int c, input logic [AB-1:0] a);
    pend_rd[c] = 1'b1; rd_addr[c] = a; age[c] = 0; issue_cyc[c] = cycle;
    apply_inputs();
  endtask

  task automatic issue_wr(input int c, input logic [AB-1:0] a, input logic [DB-1:0] d);
    pend_wr[c] = 1'b1; wr_addr[c] = a; wr_data[c] = d; age[c] = 0; issue_cyc[c] = cycle;
    apply_inputs();
  endtask

  function automatic bit idle_consumer(input int c);
    return !pend_rd[c] && !pend_wr[c] && !consumer_read_ready[c] && !consumer_write_ready[c];
  endfunction

  function automatic bit busy();
    bit b = (consumer_read_ready != '0) || (consumer_write_ready != '0);
    for (int c = 0; c < NC; c++) if (pend_rd[c] || pend_wr[c]) b = 1'b1;
    return b;
  endfunction

  task automatic step();
    for (int ch = 0; ch < NCH; ch++) begin
      if (mem_read_valid[ch] && mem_read_ready[ch]) rd_hs++;
      if (mem_write_valid[ch] && mem_write_ready[ch])
        landed.push_back({mem_write_address[ch*AB +: AB], mem_write_data[ch*DB +: DB]});
    end
    @(posedge clk); #1; cycle++;
    for (int ch = 0; ch < NCH; ch++) begin
      if (!reset && prev_mrv[ch] && mem_read_valid[ch])
        check_eq("rd_addr_stable", mem_read_address[ch*AB +: AB], prev_mra[ch]);
      if (!reset && prev_mwv[ch] && mem_write_valid[ch]) begin
        check_eq("wr_addr_stable", mem_write_address[ch*AB +: AB], prev_mwa[ch]);
        check_eq("wr_data_stable", mem_write_data[ch*DB +: DB], prev_mwd[ch]);
      end
      prev_mrv[ch] = mem_read_valid[ch];  prev_mra[ch] = mem_read_address[ch*AB +: AB];
      prev_mwv[ch] = mem_write_valid[ch]; prev_mwa[ch] = mem_write_address[ch*AB +: AB];
      prev_mwd[ch] = mem_write_data[ch*DB +: DB];
    end
    for (int c = 0; c < NC; c++) begin
      if (consumer_read_ready[c] && !prev_rr[c]) begin
        check_eq("rd_unrequested", pend_rd[c], 1);
        if (pend_rd[c]) begin
          check_eq("rd_data", consumer_read_data[c*DB +: DB], mem_model[rd_addr[c]]);
          last_lat[c] = cycle - issue_cyc[c];
          pend_rd[c] = 1'b0; rd_served++; order.push_back(c*2);
        end
      end
      if (consumer_write_ready[c] && !prev_wr[c]) begin
        check_eq("wr_unrequested", pend_wr[c], 1);
        if (pend_wr[c]) begin
          int fi = -1;
          for (int i = 0; i < landed.size(); i++)
            if (fi < 0 && landed[i] == {wr_addr[c], wr_data[c]}) fi = i;
          check_eq("wr_landed", fi >= 0, 1);
          if (fi >= 0) landed.delete(fi);
          pend_wr[c] = 1'b0; order.push_back(c*2 + 1);
        end
      end
      prev_rr[c] = consumer_read_ready[c];
      prev_wr[c] = consumer_write_ready[c];
      if (pend_rd[c] || pend_wr[c]) begin
        age[c]++;
        if (age[c] > TIMEOUT) begin
          check_eq("req_timeout", age[c], TIMEOUT);
          pend_rd[c] = 1'b0; pend_wr[c] = 1'b0;
        end
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      logic [AB-1:0] ra, wa;
      ra = mem_read_address[ch*AB +: AB];
      wa = mem_write_address[ch*AB +: AB];
      mem_read_data[ch*DB +: DB] = mem_model[ra];
      case (mode)
        M_ALWAYS:   begin mem_read_ready[ch] = 1'b1; mem_write_ready[ch] = 1'b1; end
        M_RANDOM:   begin mem_read_ready[ch] = 1'($urandom); mem_write_ready[ch] = 1'($urandom); end
        M_STALL_HI: begin mem_read_ready[ch] = (ra < 8'hF0); mem_write_ready[ch] = (wa < 8'hF0); end
        default:    begin mem_read_ready[ch] = 1'b0; mem_write_ready[ch] = 1'b0; end
      endcase
    end
    apply_inputs();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (busy() && n < limit) begin step(); n++; end
    check_eq("drain_idle", busy(), 0);
  endtask

  task automatic phase_end();
    check_eq("rd_hs_vs_served", rd_hs, rd_served);
    check_eq("wr_leftover", landed.size(), 0);
    rd_hs = 0; rd_served = 0; landed.delete(); order.delete();
  endtask

  initial begin
    int f, reissue, n;
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
    mem_model[8'h10] = 32'h0040_0000;
    for (int c = 0; c < NC; c++) begin
      pend_rd[c] = 0; pend_wr[c] = 0; rd_addr[c] = '0; wr_addr[c] = '0; wr_data[c] = '0;
      prev_rr[c] = 0; prev_wr[c] = 0; age[c] = 0; issue_cyc[c] = 0; last_lat[c] = 0;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      prev_mrv[ch] = 0; prev_mwv[ch] = 0; prev_mra[ch] = '0; prev_mwa[ch] = '0; prev_mwd[ch] = '0;
    end
    mem_read_ready = '0; mem_write_ready = '0; mem_read_data = '0;
    apply_inputs();
    reset = 1'b1;
    repeat (2) step();
    check_eq("rst_rd_ready", consumer_read_ready, 0);
    check_eq("rst_wr_ready", consumer_write_ready, 0);
    check_eq("rst_rd_data", |consumer_read_data, 0);
    check_eq("rst_mem_rd_valid", mem_read_valid, 0);
    check_eq("rst_mem_wr_valid", mem_write_valid, 0);
    check_eq("rst_mem_addr_data", |{mem_read_address, mem_write_address, mem_write_data}, 0);
    reset = 1'b0;
    step();

    // Consumer 3 read with always-ready memory: ready two edges after request.
    issue_rd(3, 8'h10);
    step();
    check_eq("c3_mem_rd_valid_cnt", $countones(mem_read_valid), 1);
    step();
    check_eq("c3_rd_ready", consumer_read_ready[3], 1);
    check_eq("c3_rd_data", consumer_read_data[3*DB +: DB], 32'h0040_0000);
    check_eq("c3_latency", last_lat[3], 2);
    drain(50); phase_end();

    // Consumer 5 write.
    issue_wr(5, 8'h02, 32'hDEAD_BEEF);
    step();
    f = 0;
    for (int ch = 0; ch < NCH; ch++)
      if (mem_write_valid[ch] && mem_write_address[ch*AB +: AB] == 8'h02 &&
          mem_write_data[ch*DB +: DB] == 32'hDEAD_BEEF) f++;
    check_eq("c5_mem_wr_issued", f, 1);
    step();
    check_eq("c5_wr_ready", consumer_write_ready[5], 1);
    drain(50); phase_end();

    // All consumers read at once: every channel busy, everyone served once.
    for (int c = 0; c < NC; c++) issue_rd(c, 8'h40 + 8'(c));
    step();
    check_eq("all_channels_busy", $countones(mem_read_valid), NCH);
    drain(100);
    check_eq("all_served", rd_served, NC);
    phase_end();

    // Simultaneous read and write from one consumer: read first.
    issue_rd(4, 8'h55);
    issue_wr(4, 8'h66, $urandom);
    drain(100);
    check_eq("rw_count", order.size(), 2);
    check_eq("rw_first_read", order[0], 8);
    check_eq("rw_then_write", order[1], 9);
    phase_end();

    // Contention on a single free channel: consumer 0 keeps requesting, consumer 1 waits.
    mode = M_STALL_HI;
    issue_rd(5, 8'hF5); issue_rd(6, 8'hF6); issue_rd(7, 8'hF7);
    step();
    issue_rd(0, 8'h20); issue_rd(1, 8'h21);
    reissue = 2; n = 0;
    while (order.size() < 2 && n < 60) begin
      step(); n++;
      if (reissue > 0 && idle_consumer(0)) begin issue_rd(0, 8'h20); reissue--; end
    end
    check_eq("arb_first", order[0], 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check_eq("arb_second_rr", order[1], 2);
`else
    check_eq("arb_second_fixed", order[1], 0);
`endif
    mode = M_ALWAYS;
    drain(200); phase_end();

    // Reset while a read waits on memory.
    mode = M_STALL_ALL;
    issue_rd(2, 8'h30);
    step(); step();
    check_eq("pre_rst_waiting", mem_read_valid != '0, 1);
    reset = 1'b1;
    step();
    check_eq("mid_rst_rd_ready", consumer_read_ready, 0);
    check_eq("mid_rst_mem_rd_valid", mem_read_valid, 0);
    check_eq("mid_rst_mem_rd_addr", mem_read_address, 0);
    check_eq("mid_rst_rd_data", |consumer_read_data, 0);
    for (int c = 0; c < NC; c++) begin pend_rd[c] = 0; pend_wr[c] = 0; end
    apply_inputs();
    reset = 1'b0;
    mode = M_ALWAYS;
    repeat (4) step();
    check_eq("post_rst_no_pulse", consumer_read_ready, 0);
    phase_end();

    // Randomized traffic.
    mode = M_RANDOM;
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int c = 0; c < NC; c++) begin
        if (idle_consumer(c) && $urandom_range(7) == 0) begin
          int r = $urandom_range(9);
          if (r < 5)      issue_rd(c, 8'($urandom_range(8'hEF)));
          else if (r < 9) issue_wr(c, 8'($urandom_range(8'hEF)), $urandom);
          else begin
            issue_rd(c, 8'($urandom_range(8'hEF)));
            issue_wr(c, 8'($urandom_range(8'hEF)), $urandom);
          end
        end
      end
    end
    drain(800); phase_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 32, memory data width (fixed-point word).
REQ-003 SHALL have parameter NUM_CONSUMERS, default 8, number of LSU requesters (cores x threads).
REQ-004 SHALL have parameter NUM_CHANNELS, default 4, number of memory channels; NUM_CHANNELS <= NUM_CONSUMERS.
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port consumer_read_valid  in  [NUM_CONSUMERS]  per-consumer read request.
REQ-008 SHALL have port consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address.
REQ-009 SHALL have port consumer_read_ready  out  [NUM_CONSUMERS]  read data valid for consumer.
REQ-010 SHALL have port consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  returned read data.
REQ-011 SHALL have port consumer_write_valid  in  [NUM_CONSUMERS]  per-consumer write request.
REQ-012 SHALL have port consumer_write_address  in  [NUM_CONSUMERS][ADDR_BITS]  write address.
REQ-013 SHALL have port consumer_write_data  in  [NUM_CONSUMERS][DATA_BITS]  write data.
REQ-014 SHALL have port consumer_write_ready  out  [NUM_CONSUMERS]  write completed.
REQ-015 SHALL have ports mem_read_valid / mem_read_address  out  [NUM_CHANNELS] / [NUM_CHANNELS][ADDR_BITS]  channel read request.
REQ-016 SHALL have ports mem_read_ready / mem_read_data  in  [NUM_CHANNELS] / [NUM_CHANNELS][DATA_BITS]  channel read response.
REQ-017 SHALL have ports mem_write_valid / mem_write_address / mem_write_data  out  [NUM_CHANNELS] / [..][ADDR_BITS] / [..][DATA_BITS]  channel write request.
REQ-018 SHALL have port mem_write_ready  in  [NUM_CHANNELS]  channel write acknowledge.

Function
REQ-019 Each channel SHALL run an independent FSM: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING; all outputs registered.
REQ-020 IDLE: channel SHALL claim the first unclaimed consumer in search order with read_valid or write_valid; read wins if both asserted; latch address/data, assert mem_*_valid next cycle, go *_WAITING.
REQ-021 A consumer SHALL be claimed by at most one channel; several idle channels in one cycle SHALL take distinct consumers, lower channel index taking the earlier consumer in search order.
REQ-022 READ_WAITING: on mem_read_ready, SHALL capture mem_read_data into consumer_read_data, assert consumer_read_ready, drop mem_read_valid, go READ_RELAYING.
REQ-023 WRITE_WAITING: on mem_write_ready, SHALL assert consumer_write_ready, drop mem_write_valid, go WRITE_RELAYING.
REQ-024 *_RELAYING: SHALL hold ready/data until consumer drops its valid, then drop ready, release claim, return to IDLE; new claim earliest the following cycle.
REQ-025 Latency with always-ready memory: consumer valid at edge N -> mem_*_valid after edge N+1 -> consumer ready after edge N+2.
REQ-026 Address/data presented to memory SHALL be the values latched at claim, stable until mem ready.
REQ-027 Requests beyond NUM_CHANNELS outstanding SHALL wait unclaimed, never dropped.

Reset
REQ-028 Reset SHALL force all FSMs to IDLE, clear claims and round-robin pointer, and drive every valid/ready output to 0 and every address/data output to 0 on the next edge, including mid-transaction.

Configuration
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN defined: search order SHALL start one past the most recently claimed consumer (wrap at NUM_CONSUMERS-1 -> 0); pointer 0 after reset.
REQ-030 Macro MEM_ARB_ROUND_ROBIN_EN undefined: search order SHALL be fixed, consumer 0 highest priority.

Verification
REQ-031 Consumer 3 read addr 0x10, mem returns 0x00400000 with ready always 1 -> consumer_read_ready[3]=1 with data 0x00400000 two edges after request.
REQ-032 Consumer 5 write addr 0x02 data 0xDEADBEEF -> mem_write_valid on one channel with that addr/data; consumer_write_ready[5]=1 after mem_write_ready.
REQ-033 All 8 consumers read simultaneously -> exactly 4 channels busy, all 8 serviced, no consumer duplicated, each read once.
REQ-034 Consumer 0 holds read_valid continuously while consumer 1 requests, RR enabled -> consumer 1 serviced before consumer 0's second claim; RR disabled -> consumer 0 wins ties.
REQ-035 Reset asserted while channel in READ_WAITING with mem_read_ready low -> all outputs 0 next edge, no consumer_read_ready pulse.
REQ-036 Consumer asserts read and write together -> read completes first, write issued after release.
